// File: rtl/demux_stripe_ctrl.sv
// demux_stripe_ctrl: credit-based round-robin byte striping across the two lanes of a 1x2 demux
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   in_i, valid_i, ready_o  input byte stream; a byte transfers when valid_i && ready_o
//   lane_en_i               per-lane enable
//   credit_ret_i            per-lane one-cycle credit return pulse
//   out_o, valid_out_o      registered byte with one-hot lane strobe
//   sel_o                   lane that receives the next accepted byte
//   credit0_o, credit1_o    per-lane credit counts
//   err_ovf_o               sticky credit-return overflow flag
module demux_stripe_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] in_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        lane_en_i,
  input  logic [1:0]        credit_ret_i,
  output logic [DATA_W-1:0] out_o,
  output logic [1:0]        valid_out_o,
  output logic              sel_o,
  output logic [CNT_W-1:0]  credit0_o,
  output logic [CNT_W-1:0]  credit1_o,
  output logic              err_ovf_o
);
  typedef enum logic [1:0] {IDLE, RUN, REALIGN} state_t;
  state_t state_q, state_d;
  logic [1:0] en_q, en_d, vout_q, vout_d;
  logic sel_q, sel_d, err_q, err_d, acc;
  logic [DATA_W-1:0] out_q, out_d;
  logic [1:0][CNT_W-1:0] cred_q, cred_d;
  // No lane skipping: a starved sel lane stalls the stream to keep strict stripe order.
  assign ready_o = state_q == RUN && cred_q[sel_q] != '0 && lane_en_i[sel_q];
  assign acc = valid_i && ready_o;
  always_comb begin
    state_d = state_q;
    en_d = en_q;
    sel_d = acc && lane_en_i[~sel_q] ? ~sel_q : sel_q;
    err_d = err_q;
    out_d = acc ? in_i : out_q;
    vout_d = acc ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    cred_d = cred_q;
    case (state_q)
      IDLE, REALIGN: begin
        state_d = |lane_en_i ? RUN : IDLE;
        if (|lane_en_i) begin
          en_d = lane_en_i;
          sel_d = ~lane_en_i[0];
        end
      end
      RUN: state_d = ~|lane_en_i ? IDLE : lane_en_i != en_q ? REALIGN : RUN;
      default: state_d = IDLE;
    endcase
    // A return and a send in the same cycle cancel; a return onto a full counter only flags.
    for (int i = 0; i < 2; i++) begin
      if (credit_ret_i[i] && !vout_d[i]) begin
        if (cred_q[i] == CNT_W'(CREDITS)) err_d = 1'b1;
        else cred_d[i] = cred_q[i] + CNT_W'(1);
      end else if (!credit_ret_i[i] && vout_d[i]) cred_d[i] = cred_q[i] - CNT_W'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      en_q <= '0;
      sel_q <= 1'b0;
      err_q <= 1'b0;
      out_q <= '0;
      vout_q <= '0;
      cred_q <= {2{CNT_W'(CREDITS)}};
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      sel_q <= sel_d;
      err_q <= err_d;
      out_q <= out_d;
      vout_q <= vout_d;
      cred_q <= cred_d;
    end
  end
  assign out_o = out_q;
  assign valid_out_o = vout_q;
  assign sel_o = sel_q;
  assign credit0_o = cred_q[0];
  assign credit1_o = cred_q[1];
  assign err_ovf_o = err_q;
endmodule

// File: tb/tb_demux_stripe_ctrl.sv
// tb_demux_stripe_ctrl: directed and random stimulus checked against a cycle-level reference model
module tb_demux_stripe_ctrl;
  localparam int DW = 8, CR = 4, CW = 3;
  logic clk = 1'b0, reset, valid, ready, sel, err_ovf;
  logic [DW-1:0] din, dout;
  logic [1:0] lane_en, credit_ret, valid_out;
  logic [CW-1:0] credit0, credit1;
  int checks = 0, failures = 0;
  int m_mode, m_cred[2];
  logic [1:0] m_en, m_vout;
  logic m_sel, m_err;
  logic [DW-1:0] m_out;

  always #5 clk = ~clk;

  demux_stripe_ctrl #(.DATA_W(DW), .CREDITS(CR), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset), .in_i(din), .valid_i(valid), .ready_o(ready),
    .lane_en_i(lane_en), .credit_ret_i(credit_ret), .out_o(dout), .valid_out_o(valid_out),
    .sel_o(sel), .credit0_o(credit0), .credit1_o(credit1), .err_ovf_o(err_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_mode = 0; m_en = 2'b00; m_sel = 1'b0; m_cred[0] = CR; m_cred[1] = CR;
    m_err = 1'b0; m_out = '0; m_vout = 2'b00;
  endtask

  // One clock: drive inputs, check ready, advance the model, check registered outputs.
  // Model modes: 0 idle, 1 run, 2 realign.
  task automatic cyc(input logic r, input logic v, input logic [DW-1:0] d,
                     input logic [1:0] en, input logic [1:0] ret);
    logic exp_rdy, acc;
    reset = r; valid = v; din = d; lane_en = en; credit_ret = ret;
    #1;
    exp_rdy = m_mode == 1 && m_cred[m_sel] > 0 && en[m_sel];
    chk("ready", ready, exp_rdy);
    acc = v && exp_rdy;
    if (r) mreset();
    else begin
      m_vout = acc ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
      if (acc) m_out = d;
      for (int i = 0; i < 2; i++) begin
        if (ret[i] && !m_vout[i]) begin
          if (m_cred[i] == CR) m_err = 1'b1;
          else m_cred[i]++;
        end else if (!ret[i] && m_vout[i]) m_cred[i]--;
      end
      if (acc && en[!m_sel]) m_sel = !m_sel;
      if (m_mode == 1) m_mode = en == 2'b00 ? 0 : en != m_en ? 2 : 1;
      else if (en != 2'b00) begin
        m_mode = 1; m_en = en; m_sel = !en[0];
      end else m_mode = 0;
    end
    @(posedge clk);
    #1;
    chk("out", dout, m_out);
    chk("valid_out", valid_out, m_vout);
    chk("sel", sel, m_sel);
    chk("credit0", credit0, m_cred[0]);
    chk("credit1", credit1, m_cred[1]);
    chk("err_ovf", err_ovf, m_err);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; din = '0; lane_en = 2'b00; credit_ret = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    mreset();
    cyc(1, 0, 8'h00, 2'b00, 2'b00);
    chk("rst_credit0", credit0, CR);
    chk("rst_ready", ready, 1'b0);
    // 1: four back-to-back bytes striped 01,10,01,10
    cyc(0, 0, 8'h00, 2'b11, 2'b00);
    cyc(0, 1, 8'hA1, 2'b11, 2'b00);
    chk("t1_vout1", valid_out, 2'b01);
    cyc(0, 1, 8'hA2, 2'b11, 2'b00);
    chk("t1_vout2", valid_out, 2'b10);
    cyc(0, 1, 8'hA3, 2'b11, 2'b00);
    cyc(0, 1, 8'hA4, 2'b11, 2'b00);
    chk("t1_out4", dout, 8'hA4);
    chk("t1_credit0", credit0, 2);
    chk("t1_credit1", credit1, 2);
    cyc(0, 0, 8'h00, 2'b11, 2'b00);
    // 2: credits exhaust after 8 bytes; a lane0 return releases the ninth
    cyc(1, 0, 8'h00, 2'b11, 2'b00);
    cyc(0, 0, 8'h00, 2'b11, 2'b00);
    for (int i = 0; i < 9; i++) cyc(0, 1, 8'(8'h10 + i), 2'b11, 2'b00);
    chk("t2_sel", sel, 1'b0);
    chk("t2_stall", ready, 1'b0);
    cyc(0, 1, 8'h19, 2'b11, 2'b01);
    cyc(0, 1, 8'h19, 2'b11, 2'b00);
    chk("t2_vout", valid_out, 2'b01);
    chk("t2_out", dout, 8'h19);
    // 3: lane_en 11 -> 01 mid-stream realigns onto lane 0
    cyc(1, 0, 8'h00, 2'b11, 2'b00);
    cyc(0, 0, 8'h00, 2'b11, 2'b00);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'h30 + i), 2'b11, 2'b00);
    cyc(0, 1, 8'h33, 2'b01, 2'b00);
    cyc(0, 1, 8'h34, 2'b01, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'(8'h35 + i), 2'b01, 2'b01);
      chk("t3_lane0", valid_out, 2'b01);
    end
    // 5: lane1 send and return in the same cycle cancel
    cyc(1, 0, 8'h00, 2'b11, 2'b00);
    cyc(0, 0, 8'h00, 2'b11, 2'b00);
    cyc(0, 1, 8'h50, 2'b11, 2'b00);
    cyc(0, 1, 8'h51, 2'b11, 2'b00);
    cyc(0, 1, 8'h52, 2'b11, 2'b00);
    cyc(0, 1, 8'h53, 2'b11, 2'b10);
    chk("t5_credit1", credit1, 3);
    chk("t5_err", err_ovf, 1'b0);
    // 4: return onto a full counter while idle sets the sticky flag
    cyc(1, 0, 8'h00, 2'b00, 2'b00);
    cyc(0, 0, 8'h00, 2'b00, 2'b01);
    chk("t4_credit0", credit0, CR);
    chk("t4_err", err_ovf, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 2'b00, 2'b00);
    chk("t4_sticky", err_ovf, 1'b1);
    // 6: reset mid-burst drops the stream and restarts from idle
    cyc(1, 0, 8'h00, 2'b11, 2'b00);
    cyc(0, 0, 8'h00, 2'b11, 2'b00);
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'h60 + i), 2'b11, 2'b00);
    cyc(1, 1, 8'h63, 2'b11, 2'b00);
    chk("t6_vout", valid_out, 2'b00);
    chk("t6_credit1", credit1, CR);
    cyc(0, 1, 8'h64, 2'b11, 2'b00);
    cyc(0, 1, 8'h65, 2'b11, 2'b00);
    chk("t6_restart", valid_out, 2'b01);
    // random traffic, enable changes and credit returns
    cyc(1, 0, 8'h00, 2'b11, 2'b00);
    for (int i = 0; i < 400; i++) begin
      logic [1:0] en, ret;
      en = $urandom_range(0, 9) == 0 ? 2'($urandom_range(0, 3)) : lane_en;
      if (i == 0) en = 2'b11;
      ret = $urandom_range(0, 2) == 0 ? 2'($urandom_range(0, 3)) : 2'b00;
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, 8'($urandom), en, ret);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
